// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default sizing for the two-producer FIFO write arbiter.
package fifo_wr_arbiter_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_DEPTH     = 8;
    localparam int unsigned DEF_MAX_BURST = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGrant0 = 2'd1,
        StGrant1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_fifo_core.sv
// Show-ahead synchronous FIFO; pointers carry a phase bit to tell full from empty.
module arb_fifo_core #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    // Phase-extended pointer difference is the occupancy, 0..DEPTH.
    assign count   = wr_ptr_q - rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Two producers time-share one FIFO under a bursting round-robin grant.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s0_valid,
    input  logic [DATA_W-1:0]        s0_data,
    output logic                     s0_ready,
    input  logic                     s1_valid,
    input  logic [DATA_W-1:0]        s1_data,
    output logic                     s1_ready,
    input  logic                     read_en,
    output logic [DATA_W-1:0]        read_data,
    output logic                     read_src,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_e         state_q;
    logic [BURST_W-1:0] burst_q;
    logic               last_served_q;

    logic               cur_id;
    logic               cur_valid;
    logic               oth_valid;
    logic               burst_last;
    logic               wr_en;
    logic [DATA_W:0]    wr_data;
    logic [DATA_W:0]    rd_data;

    assign cur_id     = (state_q == StGrant1);
    assign cur_valid  = cur_id ? s1_valid : s0_valid;
    assign oth_valid  = cur_id ? s0_valid : s1_valid;
    assign burst_last = (burst_q == BURST_W'(MAX_BURST - 1));

    assign s0_ready = (state_q == StGrant0) && !full;
    assign s1_ready = (state_q == StGrant1) && !full;
    assign wr_en    = (s0_valid && s0_ready) || (s1_valid && s1_ready);
    assign wr_data  = cur_id ? {1'b1, s1_data} : {1'b0, s0_data};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            burst_q       <= '0;
            last_served_q <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    burst_q <= '0;
                    if (s0_valid && (!s1_valid || last_served_q)) begin
                        state_q <= StGrant0;
                    end else if (s1_valid) begin
                        state_q <= StGrant1;
                    end
                end
                StGrant0, StGrant1: begin
                    // Everything freezes while full; no beat can move anyway.
                    if (!full) begin
                        if (cur_valid && !burst_last) begin
                            burst_q <= burst_q + 1'b1;
                        end else begin
                            last_served_q <= cur_id;
                            burst_q       <= '0;
                            if (oth_valid) begin
                                state_q <= cur_id ? StGrant0 : StGrant1;
                            end else if (!cur_valid) begin
                                state_q <= StIdle;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    arb_fifo_core #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (read_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

    assign read_data = rd_data[DATA_W-1:0];
    assign read_src  = rd_data[DATA_W];

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random stimulus checked against a queue-based model of the arbiter and FIFO.
module tb_fifo_wr_arbiter;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int MB    = 4;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    s0_valid = 1'b0;
    logic [DW-1:0]           s0_data = '0;
    logic                    s0_ready;
    logic                    s1_valid = 1'b0;
    logic [DW-1:0]           s1_data = '0;
    logic                    s1_ready;
    logic                    read_en = 1'b0;
    logic [DW-1:0]           read_data;
    logic                    read_src;
    logic                    empty;
    logic                    full;
    logic [$clog2(DEPTH):0]  count;

    int errors = 0;
    int checks = 0;

    // Model: owner -1 = nobody granted, beats = beats taken in current grant.
    int          m_owner = -1;
    int          m_beats = 0;
    int          m_last  = 1;
    logic [DW:0] q[$];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s0_valid  (s0_valid),
        .s0_data   (s0_data),
        .s0_ready  (s0_ready),
        .s1_valid  (s1_valid),
        .s1_data   (s1_data),
        .s1_ready  (s1_ready),
        .read_en   (read_en),
        .read_data (read_data),
        .read_src  (read_src),
        .empty     (empty),
        .full      (full),
        .count     (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model, advance the model, then cross one clock edge.
    task automatic tick();
        int  n;
        bit  mfull;
        bit  v[2];
        bit  mine;
        logic [DW:0] beat;
        #1;
        n     = q.size();
        mfull = (n == DEPTH);
        v[0]  = s0_valid;
        v[1]  = s1_valid;
        check("s0_ready", 32'(s0_ready), 32'(m_owner == 0 && !mfull));
        check("s1_ready", 32'(s1_ready), 32'(m_owner == 1 && !mfull));
        check("count", 32'(count), 32'(n));
        check("empty", 32'(empty), 32'(n == 0));
        check("full", 32'(full), 32'(mfull));
        if (n > 0) begin
            check("read_data", 32'(read_data), 32'(q[0][DW-1:0]));
            check("read_src", 32'(read_src), 32'(q[0][DW]));
        end
        if (!reset) begin
            m_owner = -1;
            m_beats = 0;
            m_last  = 1;
            q.delete();
        end else begin
            beat = (m_owner == 1) ? {1'b1, s1_data} : {1'b0, s0_data};
            if (read_en && n > 0) void'(q.pop_front());
            if (m_owner >= 0 && !mfull && v[m_owner]) q.push_back(beat);
            if (m_owner < 0) begin
                m_beats = 0;
                if (v[0] && v[1]) m_owner = 1 - m_last;
                else if (v[0]) m_owner = 0;
                else if (v[1]) m_owner = 1;
            end else if (!mfull) begin
                mine = v[m_owner];
                if (mine && m_beats + 1 < MB) begin
                    m_beats++;
                end else begin
                    m_last  = m_owner;
                    m_beats = 0;
                    if (v[1 - m_owner]) m_owner = 1 - m_owner;
                    else if (!mine) m_owner = -1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int guard;
        @(posedge clk);
        #1;

        // Reset held with producer 0 asking: no ready until reset releases.
        s0_valid = 1'b1;
        s0_data  = 8'hA5;
        tick();
        tick();
        check("rst_read_data", 32'(read_data), 32'h0);
        check("rst_read_src", 32'(read_src), 32'h0);

        // Both producers streaming, no reads: bursts of MB then fill up.
        reset    = 1'b1;
        s1_valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            s0_data = 8'($urandom);
            s1_data = 8'($urandom);
            tick();
        end
        check("fill_count", 32'(count), 32'd8);
        check("fill_full", 32'(full), 32'd1);
        check("fill_rdy0", 32'(s0_ready), 32'd0);
        check("fill_rdy1", 32'(s1_ready), 32'd0);

        // One pop while full frees a slot, the granted producer refills it.
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        check("pop_count", 32'(count), 32'd7);
        check("pop_full", 32'(full), 32'd0);
        tick();
        check("refill_count", 32'(count), 32'd8);

        // Drain everything with producers quiet.
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        read_en  = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        // Random traffic: simultaneous write/pop, pointer wrap, ties.
        for (int i = 0; i < 300; i++) begin
            s0_valid = ($urandom_range(0, 3) != 0);
            s1_valid = ($urandom_range(0, 3) != 0);
            read_en  = 1'($urandom_range(0, 1));
            s0_data  = 8'($urandom);
            s1_data  = 8'($urandom);
            tick();
        end

        // Drain, then producer 1 alone for two beats, then handover to producer 0.
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        read_en  = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        read_en  = 1'b0;
        s1_valid = 1'b1;
        s1_data  = 8'h3C;
        tick();
        tick();
        tick();
        check("s1_two_beats", 32'(count), 32'd2);
        s1_valid = 1'b0;
        s0_valid = 1'b1;
        s0_data  = 8'hC3;
        tick();
        check("handover_rdy0", 32'(s0_ready), 32'd1);
        check("handover_rdy1", 32'(s1_ready), 32'd0);

        // Drain, fill to five with producer 0, reset mid-burst.
        s0_valid = 1'b0;
        read_en  = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        read_en  = 1'b0;
        s0_valid = 1'b1;
        guard    = 0;
        while (q.size() < 5 && guard < 50) begin
            s0_data = 8'($urandom);
            tick();
            guard++;
        end
        check("pre_reset_count", 32'(count), 32'd5);
        reset = 1'b0;
        tick();
        reset    = 1'b1;
        s0_valid = 1'b0;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_data", 32'(read_data), 32'd0);
        read_en = 1'b1;
        tick();
        tick();
        read_en = 1'b0;
        check("empty_pop_count", 32'(count), 32'd0);
        check("empty_pop_empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_W, default 8, data width; DEPTH, default 8, FIFO entries (power of 2, >=2); MAX_BURST, default 4, maximum consecutive beats per grant (>=1).
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 Ports SHALL be, in order:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-low
- s0_valid  in  1  producer 0 has data
- s0_data  in  DATA_W  producer 0 data
- s0_ready  out  1  producer 0 beat accepted this cycle
- s1_valid  in  1  producer 1 has data
- s1_data  in  DATA_W  producer 1 data
- s1_ready  out  1  producer 1 beat accepted this cycle
- read_en  in  1  consumer pops head
- read_data  out  DATA_W  head entry data, show-ahead
- read_src  out  1  producer ID of head entry
- empty  out  1  FIFO holds 0 entries
- full  out  1  FIFO holds DEPTH entries
- count  out  $clog2(DEPTH)+1  current occupancy

Function
REQ-004 Writes SHALL be the two producers' beats, time-shared into one FIFO; at most one beat is written per cycle.
REQ-005 A beat from producer N SHALL transfer when sN_valid && sN_ready; the stored entry is {N, sN_data}.
REQ-006 sN_ready SHALL be 1 exactly when state == GRANTN and full == 0; it SHALL not depend on sN_valid.
REQ-007 Arbiter states SHALL be IDLE, GRANT0 and GRANT1, registered, with a burst counter (0..MAX_BURST-1) and a last-served flag.
REQ-008 From IDLE: only s0_valid -> GRANT0; only s1_valid -> GRANT1; both -> GRANT of the producer not last served; neither -> IDLE.
REQ-009 In GRANTN the grant SHALL end when sN_valid == 0, or when a transfer occurs with burst counter == MAX_BURST-1.
REQ-010 On grant end, the next state SHALL be GRANT of the other producer if its valid is 1; else GRANTN again if sN_valid is 1 (new burst); else IDLE; there is no IDLE bubble on handover.
REQ-011 The burst counter SHALL increment on each transfer, reset to 0 on every new grant, and hold while full.
REQ-012 While full == 1 the grant, burst counter and last-served flag SHALL hold.
REQ-013 The last-served flag SHALL update to N when a grant to N ends.
REQ-014 A grant SHALL become visible as sN_ready one cycle after the state update; with both valids held, the output sequence SHALL be MAX_BURST beats of one producer, then MAX_BURST of the other.
REQ-015 read_data/read_src SHALL present the head entry combinationally; a pop SHALL occur when read_en && !empty; read_en while empty SHALL be ignored.
REQ-016 count SHALL be +1 on write only, -1 on pop only, and unchanged when both occur in the same cycle.
REQ-017 A write while full SHALL be impossible because ready is 0; a pop while full SHALL free one entry, visible the next cycle.
REQ-018 Pointers SHALL be $clog2(DEPTH) bits plus a phase bit toggling on wrap; full = phases differ && indices equal; empty = phases equal && indices equal.

Reset
REQ-019 When reset == 0 at a clock edge, the block SHALL set: state IDLE; burst 0; last-served = 1 (producer 0 wins first tie); pointers and phases 0; storage cleared.
REQ-020 After reset the outputs SHALL be: count 0, empty 1, full 0, s0_ready/s1_ready 0, read_data 0, read_src 0.
REQ-021 A reset during a burst SHALL discard all stored entries and the grant with no partial effects.

Structure
REQ-022 The shared package SHALL hold the arbiter state enum and the default constants DATA_W, DEPTH and MAX_BURST.
REQ-023 The storage SHALL be a sub-module arb_fifo_core (DATA_W+1 wide, pointer/phase logic, count), instantiated once; arbitration stays in fifo_wr_arbiter.

Verification
REQ-024 Reset with s0_valid=1 -> s0_ready=0 during reset; GRANT0 one cycle after reset deasserts; first entry {0,data}.
REQ-025 Both valid continuously, no reads, DEPTH=8, MAX_BURST=4 -> entries 0-3 src 0, entries 4-7 src 1; full=1 and count=8 after the 8th beat; both readies then 0.
REQ-026 When full, assert read_en for one cycle -> count 8->7, full=0 next cycle; granted producer writes next and count returns to 8.
REQ-027 Write and pop in the same cycle at count=3 -> count stays 3; data is FIFO-ordered across 20 beats including pointer wrap.
REQ-028 Only s1_valid, dropped after 2 beats, then s0_valid -> GRANT1 ends; GRANT0 next cycle; last-served=1.
REQ-029 Assert reset mid-burst at count=5 -> count=0, empty=1, state IDLE; read_en afterwards is ignored.
